regfile_32x32: RTL and testbench

//   32-entry x 32-bit register file with two combinational read ports and one synchronous write port.
//   - A 5:32 write decoder selects one storage register.
//   - Each read port is a 32:1 x 32-bit select over the 32 storage outputs.
//   - Sits between the writeback stage (producer of wr_*) and the operand-fetch/ALU stage (consumer of rd_data*).

---
 rtl/regfile_32x32.sv | 149 ++++++++++++++
 tb/tb_regfile_32x32.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_32x32.sv
// Purpose : 32-entry register file with two combinational read ports and one synchronous write port.
// Latency : writes land on the rising edge after wr_en is sampled; reads are combinational (zero cycles).
// Backpres: none; every write is accepted each cycle, and the file never stalls the producer or consumer.
//
// Ports
//   clk       rising-edge clock for all storage updates
//   rst_n     asynchronous active-low reset; clears every register immediately
//   wr_en     write enable, sampled on the rising clock edge
//   wr_addr   index of the register to write
//   wr_data   data to write
//   rd_addr1  read port 1 index
//   rd_addr2  read port 2 index
//   rd_data1  read port 1 data (combinational)
//   rd_data2  read port 2 data (combinational)
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read of the register being written this
//                      cycle returns wr_data immediately instead of the old contents.
//                      Stored contents after every edge are the same in both builds.
//
// Parameters
//   WIDTH     data width of each register and of the data ports
//   ZERO_REG  1: register 0 is hard-wired to zero and ignores writes
//             0: register 0 is ordinary storage

module regfile_32x32 #(
    parameter int WIDTH    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_addr1,
    input  logic [4:0]       rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2
);

    localparam int DEPTH = 32;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] regs [DEPTH];

    // ------------------------------------------------------------------
    // Write decoder
    // wr_sel is one-hot when wr_en is high and all-zero otherwise.
    // wr_mask removes register 0 when it is hard-wired, so a write to
    // address 0 becomes a harmless no-op rather than a special case.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] wr_sel;
    logic [DEPTH-1:0] wr_mask;

    always_comb begin
        wr_sel = '0;
        if (wr_en) begin
            wr_sel[wr_addr] = 1'b1;
        end
    end

    always_comb begin
        wr_mask = wr_sel;
        if (ZERO_REG) begin
            wr_mask[0] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register array
    // One process owns the whole array so that every element has a
    // single driver. Reset wins over a concurrent write because the
    // asynchronous branch takes priority.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_mask[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // The stored value is forced to zero for address 0 when hard-wired,
    // which keeps the read side correct even if the storage flop for
    // register 0 is later removed by synthesis.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;

    always_comb begin
        stored1 = regs[rd_addr1];
        if (ZERO_REG && (rd_addr1 == 5'd0)) begin
            stored1 = '0;
        end
    end

    always_comb begin
        stored2 = regs[rd_addr2];
        if (ZERO_REG && (rd_addr2 == 5'd0)) begin
            stored2 = '0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding reuses wr_mask: it already encodes wr_en, the target
    // address and the register-0 exclusion, so the forward condition is
    // exactly "this register is about to be written". rst_n gating keeps
    // reads at zero while reset is held.
    logic fwd1;
    logic fwd2;

    always_comb begin
        fwd1 = rst_n && wr_mask[rd_addr1];
        fwd2 = rst_n && wr_mask[rd_addr2];
    end

    always_comb begin
        rd_data1 = stored1;
        if (fwd1) begin
            rd_data1 = wr_data;
        end
    end

    always_comb begin
        rd_data2 = stored2;
        if (fwd2) begin
            rd_data2 = wr_data;
        end
    end
`else
    // Without forwarding, a same-cycle read of the register being
    // written sees the old contents until the edge.
    always_comb begin
        rd_data1 = stored1;
        rd_data2 = stored2;
    end
`endif

endmodule

// File: tb/tb_regfile_32x32.sv
// Purpose : self-checking bench for regfile_32x32 using a queue-based scoreboard.
// Latency : reads are checked inside the cycle they are issued; writes are checked after the edge.
// Backpres: none; the stimulus drives one write and one read pair per probe.
`timescale 1ns/100ps

module tb_regfile_32x32;

    localparam int W  = 32;
    localparam bit ZR = 1'b1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic [4:0]   rd_addr1;
    logic [4:0]   rd_addr2;
    logic [W-1:0] rd_data1;
    logic [W-1:0] rd_data2;

    always #5 clk = ~clk;

    regfile_32x32 #(.WIDTH(W), .ZERO_REG(ZR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    // Reference model: plain array of register contents
    logic [W-1:0] model [32];

    typedef struct {
        string        name;
        logic [4:0]   a1;
        logic [4:0]   a2;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } exp_t;

    exp_t sbq[$];
    logic sample_req = 1'b0;
    int   n_checks   = 0;
    int   n_fail     = 0;

    // Expected read value for an address, from the architectural rules
    function automatic logic [W-1:0] exp_rd(input logic [4:0] a);
        if (!rst_n) return '0;
        if (ZR && a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] a, input logic [W-1:0] d);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
    endtask

    // Drive read addresses, let them settle, push the expectation, and
    // hand the sample to the monitor.
    task automatic probe(input string nm, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        rd_addr1 = a1;
        rd_addr2 = a2;
        #0.1;
        e.name = nm;
        e.a1   = a1;
        e.a2   = a2;
        e.e1   = exp_rd(a1);
        e.e2   = exp_rd(a2);
        sbq.push_back(e);
        sample_req = ~sample_req;
        #0.1;
    endtask

    // Advance one clock edge and update the model with what the edge commits
    task automatic tick();
        @(posedge clk);
        if (rst_n && wr_en && !(ZR && wr_addr == 5'd0)) model[wr_addr] = wr_data;
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_clear();
    endtask

    // Monitor: pop and compare whenever the stimulus presents a sample
    initial begin
        exp_t e;
        forever begin
            @(sample_req);
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: sample with no expectation queued");
            end else begin
                e = sbq.pop_front();
                n_checks++;
                if (rd_data1 !== e.e1) begin
                    n_fail++;
                    $display("FAIL %s port1 addr=%0d got=%h expected=%h", e.name, e.a1, rd_data1, e.e1);
                end
                n_checks++;
                if (rd_data2 !== e.e2) begin
                    n_fail++;
                    $display("FAIL %s port2 addr=%0d got=%h expected=%h", e.name, e.a2, rd_data2, e.e2);
                end
            end
        end
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] ra1, ra2;
        rst_n    = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        set_wr(1'b0, 5'd0, '0);
        model_clear();

        // Reset state
        #1;
        for (int i = 0; i < 32; i += 4) probe("reset_state", 5'(i), 5'(31 - i));
        tick();
        tick();
        rst_n = 1'b1;

        // Load random values everywhere, then pulse reset mid-cycle
        for (int i = 0; i < 32; i++) begin
            set_wr(1'b1, 5'(i), W'($urandom));
            tick();
        end
        set_wr(1'b0, 5'd0, '0);
        for (int i = 0; i < 32; i += 2) probe("random_load", 5'(i), 5'(i + 1));
        tick();
        assert_reset();
        for (int i = 0; i < 32; i++) probe("async_reset", 5'(i), 5'(31 - i));
        tick();
        rst_n = 1'b1;

        // Walking writes, then read everything back on both ports
        for (int i = 1; i < 32; i++) begin
            set_wr(1'b1, 5'(i), 32'hA5A5_0000 + W'(i));
            tick();
        end
        set_wr(1'b0, 5'd0, '0);
        for (int i = 0; i < 32; i++) probe("walk", 5'(i), 5'((i + 1) % 32));
        tick();

        // Register 0 ignores writes
        set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        probe("zero_reg_pre", 5'd0, 5'd0);
        tick();
        set_wr(1'b0, 5'd0, '0);
        probe("zero_reg_post", 5'd0, 5'd1);

        // wr_en low holds register 5 across three edges
        set_wr(1'b0, 5'd5, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            tick();
            probe("wr_en_low", 5'd5, 5'd5);
        end

        // Same-cycle read of the register being written
        set_wr(1'b1, 5'd7, 32'h1111);
        tick();
        set_wr(1'b1, 5'd7, 32'h2222);
        probe("same_cycle_pre", 5'd7, 5'd7);
        tick();
        set_wr(1'b0, 5'd0, '0);
        probe("same_cycle_post", 5'd7, 5'd7);

        // Back-to-back writes to one address
        for (int k = 1; k <= 3; k++) begin
            set_wr(1'b1, 5'd9, W'(k * 32'h0101_0101));
            tick();
            probe("back_to_back", 5'd9, 5'd10);
        end
        set_wr(1'b0, 5'd0, '0);

        // Reset held across a write edge: reset wins
        set_wr(1'b1, 5'd3, 32'h55);
        assert_reset();
        probe("reset_during_write_pre", 5'd3, 5'd9);
        tick();
        probe("reset_during_write_edge", 5'd3, 5'd3);
        rst_n = 1'b1;
        set_wr(1'b0, 5'd0, '0);
        probe("reset_during_write_post", 5'd3, 5'd7);

        // First write after reset is honoured on the first edge
        set_wr(1'b1, 5'd3, 32'h77);
        tick();
        set_wr(1'b0, 5'd0, '0);
        probe("first_write_after_reset", 5'd3, 5'd3);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            set_wr(1'($urandom_range(0, 3) != 0), 5'($urandom), W'($urandom));
            ra1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            probe("random", ra1, ra2);
            tick();
        end
        set_wr(1'b0, 5'd0, '0);
        for (int i = 0; i < 32; i += 2) probe("final_sweep", 5'(i), 5'(i + 1));

        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
